// File: rtl/i2c_mem_controller.sv
// I2C-style slave front end: oversampled SCL/SDA, address match,
// write bytes out on dataout with a strobe, read bytes serialised from data.
module i2c_mem_controller #(
  parameter logic [6:0] DEV_ADDR    = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] data,
  output logic [7:0] dataout,
  output logic       wr_strobe,
  output logic       ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_IGNORE,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

  state_t     r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic       r_done, w_done_n;
  logic [7:0] r_rx, w_rx_n;
  logic [7:0] r_tx, w_tx_n;
  logic       r_rw, w_rw_n;
  logic       r_oe, w_oe_n;
  logic [7:0] r_dout, w_dout_n;
  logic       r_stb, w_stb_n;
  logic       r_ack, w_ack_n;

  // Synchronisers idle high so reset release never looks like a START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_done  <= 1'b0;
      r_rx    <= 8'h00;
      r_tx    <= 8'h00;
      r_rw    <= 1'b0;
      r_oe    <= 1'b0;
      r_dout  <= 8'h00;
      r_stb   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
      r_rx    <= w_rx_n;
      r_tx    <= w_tx_n;
      r_rw    <= w_rw_n;
      r_oe    <= w_oe_n;
      r_dout  <= w_dout_n;
      r_stb   <= w_stb_n;
      r_ack   <= w_ack_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_done_n  = r_done;
    w_rx_n    = r_rx;
    w_tx_n    = r_tx;
    w_rw_n    = r_rw;
    w_oe_n    = r_oe;
    w_dout_n  = r_dout;
    w_stb_n   = 1'b0;
    w_ack_n   = r_ack;
    if (w_start) begin
      w_state_n = S_ADDR;
      w_cnt_n   = 3'd0;
      w_done_n  = 1'b0;
      w_ack_n   = 1'b0;
      w_oe_n    = 1'b0;
    end else if (w_stop) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 3'd0;
      w_done_n  = 1'b0;
      w_oe_n    = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR, S_WR: begin
          if (w_rise) begin
            w_rx_n  = {r_rx[6:0], w_sda};
            w_cnt_n = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_done_n = 1'b1;
          end else if (w_fall && r_done) begin
            w_done_n = 1'b0;
            if (r_state == S_WR) begin
              w_dout_n  = r_rx;
              w_stb_n   = 1'b1;
              w_oe_n    = 1'b1;
              w_ack_n   = 1'b1;
              w_state_n = S_WR_ACK;
            end else if (r_rx[7:1] == DEV_ADDR) begin
              w_oe_n    = 1'b1;
              w_ack_n   = 1'b1;
              w_rw_n    = r_rx[0];
              w_state_n = S_ADDR_ACK;
            end else begin
              w_oe_n    = 1'b0;
              w_ack_n   = 1'b0;
              w_state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_fall) begin
            if (r_rw) begin
              w_tx_n    = data;
              w_oe_n    = ~data[7];
              w_state_n = S_RD;
            end else begin
              w_oe_n    = 1'b0;
              w_state_n = S_WR;
            end
          end
        end
        S_WR_ACK: begin
          if (w_fall) begin
            w_oe_n    = 1'b0;
            w_state_n = S_WR;
          end
        end
        S_RD: begin
          if (w_rise) begin
            w_cnt_n = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_done_n = 1'b1;
          end else if (w_fall) begin
            if (r_done) begin
              w_done_n  = 1'b0;
              w_oe_n    = 1'b0;
              w_state_n = S_RD_ACK;
            end else begin
              w_tx_n = {r_tx[6:0], 1'b0};
              w_oe_n = ~r_tx[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_rise) begin
            if (w_sda) w_state_n = S_IGNORE;
            else       w_done_n  = 1'b1;
          end else if (w_fall && r_done) begin
            w_done_n  = 1'b0;
            w_tx_n    = data;
            w_oe_n    = ~data[7];
            w_state_n = S_RD;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = r_oe;
  assign dataout   = r_dout;
  assign wr_strobe = r_stb;
  assign ack       = r_ack;

endmodule

// File: tb/tb_i2c_mem_controller.sv
// Directed bench for i2c_mem_controller: bus-level master model,
// table of write transactions plus read, repeated START and reset sequences.
module tb_i2c_mem_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data;
  logic [7:0] dataout;
  logic       wr_strobe;
  logic       ack;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int overlap = 0;
  bit oe_seen = 0;
  logic prev_stb = 1'b0;

  always #5 clk = ~clk;

  assign sda_in = m_sda & ~sda_oe;

  i2c_mem_controller #(.DEV_ADDR(7'h55), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .data(data), .dataout(dataout),
    .wr_strobe(wr_strobe), .ack(ack)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (wr_strobe) strobes++;
      if (wr_strobe && prev_stb) overlap++;
      if (sda_oe) oe_seen = 1;
    end
    prev_stb = wr_strobe;
  end

  typedef struct {
    logic [6:0] addr;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       exp_ack;
    logic [7:0] exp_dout;
    int         exp_stb;
  } wvec_t;

  wvec_t vecs[3];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq();
    scl = 1'b1;   wq();
    m_sda = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    scl = 1'b1;   wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;  wq();
    scl = 1'b1; wq();
    scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wq();
    scl = 1'b1;   wq();
    acked = ~sda_in;
    scl = 1'b0;   wq();
  endtask

  task automatic read_byte(output logic [7:0] rb, input logic mack,
                           input logic [7:0] nxt);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl = 1'b1; wq();
      rb[i] = sda_in;
      scl = 1'b0;
    end
    data = nxt;
    m_sda = mack; wq();
    scl = 1'b1;   wq();
    scl = 1'b0;   wq();
    m_sda = 1'b1;
  endtask

  logic       a;
  logic [7:0] rb;

  initial begin
    vecs[0] = '{7'h55, 1, 8'hAB, 8'h00, 1'b1, 8'hAB, 1};
    vecs[1] = '{7'h2A, 1, 8'h3C, 8'h00, 1'b0, 8'hAB, 0};
    vecs[2] = '{7'h55, 2, 8'h12, 8'h34, 1'b1, 8'h34, 2};

    rst = 1'b1; scl = 1'b1; m_sda = 1'b1; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("reset ack", {7'd0, ack}, 8'h00);
    chk("reset dataout", dataout, 8'h00);
    chk("reset wr_strobe", {7'd0, wr_strobe}, 8'h00);
    rst = 1'b0;
    wq();

    for (int v = 0; v < 3; v++) begin
      strobes = 0; oe_seen = 0;
      bus_start();
      send_byte({vecs[v].addr, 1'b0}, a);
      chk($sformatf("v%0d addr ack", v), {7'd0, a}, {7'd0, vecs[v].exp_ack});
      send_byte(vecs[v].b0, a);
      chk($sformatf("v%0d b0 ack", v), {7'd0, a}, {7'd0, vecs[v].exp_ack});
      if (vecs[v].n > 1) begin
        send_byte(vecs[v].b1, a);
        chk($sformatf("v%0d b1 ack", v), {7'd0, a}, {7'd0, vecs[v].exp_ack});
      end
      bus_stop(); wq();
      chk($sformatf("v%0d dataout", v), dataout, vecs[v].exp_dout);
      chk($sformatf("v%0d strobes", v), 8'(strobes), 8'(vecs[v].exp_stb));
      chk($sformatf("v%0d ack", v), {7'd0, ack}, {7'd0, vecs[v].exp_ack});
      chk($sformatf("v%0d oe_seen", v), {7'd0, oe_seen}, {7'd0, vecs[v].exp_ack});
    end

    // single read with master NACK
    strobes = 0; data = 8'hAA;
    bus_start();
    send_byte(8'hAB, a);
    chk("rd addr ack", {7'd0, a}, 8'h01);
    read_byte(rb, 1'b1, 8'h00);
    chk("rd byte", rb, 8'hAA);
    wq();
    chk("rd released", {7'd0, sda_oe}, 8'h00);
    bus_stop();
    chk("rd strobes", 8'(strobes), 8'h00);
    chk("rd ack hold", {7'd0, ack}, 8'h01);

    // repeated START discards a partial write byte
    strobes = 0;
    bus_start();
    send_byte(8'hAA, a);
    chk("rs wr addr ack", {7'd0, a}, 8'h01);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    data = 8'h5C;
    bus_start();
    send_byte(8'hAB, a);
    chk("rs rd addr ack", {7'd0, a}, 8'h01);
    read_byte(rb, 1'b0, 8'h81);
    chk("rs byte0", rb, 8'h5C);
    read_byte(rb, 1'b1, 8'h00);
    chk("rs byte1", rb, 8'h81);
    bus_stop();
    chk("rs strobes", 8'(strobes), 8'h00);
    chk("rs dataout", dataout, 8'h34);

    // reset while controller drives the write ACK
    bus_start();
    send_byte(8'hAA, a);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    chk("pre-rst oe", {7'd0, sda_oe}, 8'h01);
    rst = 1'b1;
    #1;
    chk("rst oe", {7'd0, sda_oe}, 8'h00);
    chk("rst ack", {7'd0, ack}, 8'h00);
    chk("rst dataout", dataout, 8'h00);
    m_sda = 1'b1; scl = 1'b1;
    wq();
    rst = 1'b0;
    wq();
    strobes = 0;
    bus_start();
    send_byte(8'hAA, a);
    send_byte(8'h77, a);
    chk("post-rst ack", {7'd0, a}, 8'h01);
    bus_stop(); wq();
    chk("post-rst dataout", dataout, 8'h77);
    chk("post-rst strobes", 8'(strobes), 8'h01);
    chk("strobe width", 8'(overlap), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
